// File: rtl/divmod_pkg.sv
//------------------------------------------------------------------------------
// divmod_pkg: shared width default, FSM state and op encodings for divmod_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package divmod_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic OP_DIV = 1'b0;
  localparam logic OP_MOD = 1'b1;

endpackage : divmod_pkg

`default_nettype wire

// File: rtl/divmod_if.sv
//------------------------------------------------------------------------------
// divmod_if: request, shared-subtractor and result signals of divmod_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface divmod_if #(
  parameter int WIDTH = divmod_pkg::DEF_WIDTH
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sub_a;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] sub_result;
  logic             busy;
  logic             done;
  logic             we;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, sub_result,
    input  sub_a, sub_b, busy, done, we, result, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, op, a, b, sub_result,
    output sub_a, sub_b, busy, done, we, result, quotient, remainder, div_by_zero
  );

endinterface : divmod_if

`default_nettype wire

// File: rtl/divmod_dp.sv
//------------------------------------------------------------------------------
// divmod_dp: restoring shift-subtract datapath (Q/R/D registers, iteration count)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divmod_dp
  import divmod_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             load_i,
  input  wire logic             step_i,
  input  wire logic             dz_i,
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  input  wire logic [WIDTH-1:0] sub_result_i,
  output logic      [WIDTH-1:0] sub_a_o,
  output logic      [WIDTH-1:0] sub_b_o,
  output logic      [WIDTH-1:0] q_nxt_o,
  output logic      [WIDTH-1:0] r_nxt_o,
  output logic                  last_o
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] trial;
  logic             carry;
  logic             ge;

  // The bit shifted out of R means trial >= 2^WIDTH > D, so it always subtracts.
  assign trial = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign carry = r_q[WIDTH-1];
  assign ge    = carry | (trial >= d_q);

  assign sub_a_o = step_i ? trial : '0;
  assign sub_b_o = step_i ? d_q   : '0;
  assign last_o  = (cnt_q == CNT_LAST);
  assign q_nxt_o = q_d;
  assign r_nxt_o = r_d;

  always_comb begin
    q_d   = q_q;
    r_d   = r_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    if (load_i) begin
      d_d   = b_i;
      cnt_d = '0;
      if (dz_i) begin
        q_d = '1;
        r_d = a_i;
      end else begin
        q_d = a_i;
        r_d = '0;
      end
    end else if (step_i) begin
      r_d   = ge ? sub_result_i : trial;
      q_d   = {q_q[WIDTH-2:0], ge};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      r_q   <= r_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

endmodule : divmod_dp

`default_nettype wire

// File: rtl/divmod_ctrl.sv
//------------------------------------------------------------------------------
// divmod_ctrl: multicycle unsigned divide/modulo sequencer using a shared subtractor
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divmod_ctrl
  import divmod_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  divmod_if.slave   bus
);

  state_t state_q, state_d;

  logic             load;
  logic             step;
  logic             dz;
  logic             last;
  logic             capture;
  logic             op_sel;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] r_nxt;

  logic             op_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] res_q;

  divmod_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (load),
    .step_i       (step),
    .dz_i         (dz),
    .a_i          (bus.a),
    .b_i          (bus.b),
    .sub_result_i (bus.sub_result),
    .sub_a_o      (bus.sub_a),
    .sub_b_o      (bus.sub_b),
    .q_nxt_o      (q_nxt),
    .r_nxt_o      (r_nxt),
    .last_o       (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    dz      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          dz      = (bus.b == '0);
          state_d = dz ? FINISH : DIVIDE;
        end
      end
      DIVIDE: begin
        step = 1'b1;
        if (last) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Results are captured on the edge that enters FINISH so they are stable at Done.
  assign capture = (load && dz) || (step && last);
  assign op_sel  = load ? bus.op : op_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q   <= OP_DIV;
      dbz_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      res_q  <= '0;
    end else begin
      if (load) begin
        op_q  <= bus.op;
        dbz_q <= dz;
      end
      if (capture) begin
        quot_q <= q_nxt;
        rem_q  <= r_nxt;
        res_q  <= (op_sel == OP_MOD) ? r_nxt : q_nxt;
      end
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FINISH);
  assign bus.we          = bus.done;
  assign bus.result      = res_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule : divmod_ctrl

`default_nettype wire

// File: tb/tb_divmod_ctrl.sv
//------------------------------------------------------------------------------
// tb_divmod_ctrl: table-driven and randomized self-checking bench for divmod_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_divmod_ctrl;
  import divmod_pkg::*;

  localparam int W       = 32;
  localparam int TIMEOUT = 100;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;   // posedges after the Start edge until Done is seen
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  divmod_if #(.WIDTH(W)) bus ();

  // Shared subtractor lives outside the controller.
  assign bus.sub_result = bus.sub_a - bus.sub_b;

  divmod_ctrl #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    vec_t v;
    v.a  = a;
    v.b  = b;
    v.op = op;
    v.dz = (b == 0);
    v.q  = v.dz ? {W{1'b1}} : a / b;
    v.r  = v.dz ? a : a % b;
    v.lat = v.dz ? 0 : W;
    return v;
  endfunction

  // Issue one request; with hold set, Start stays high and the operands change
  // after acceptance. Returns the observed latency and the first Sub_B value.
  task automatic do_op(input vec_t v, input logic hold,
                       output int lat, output logic [W-1:0] sb_first, output logic busy0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.op    = v.op;
    @(posedge clk);
    #1;
    if (hold) begin
      bus.a  = ~v.a;
      bus.b  = v.b + 32'd3;
      bus.op = ~v.op;
    end else begin
      bus.start = 1'b0;
    end
    sb_first = bus.sub_b;
    busy0    = bus.busy;
    lat      = 0;
    while (!bus.done && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic verify(input string tag, input vec_t v, input int lat,
                        input logic [W-1:0] sb_first, input logic busy0);
    logic [W-1:0] exp_res;
    exp_res = v.op ? v.r : v.q;
    chk({tag, " latency"}, W'(lat), W'(v.lat));
    chk({tag, " busy_after_start"}, W'(busy0), W'(1));
    if (!v.dz) chk({tag, " first_sub_b"}, sb_first, v.b);
    chk({tag, " done"}, W'(bus.done), W'(1));
    chk({tag, " we"}, W'(bus.we), W'(1));
    chk({tag, " busy_in_finish"}, W'(bus.busy), W'(1));
    chk({tag, " result"}, bus.result, exp_res);
    chk({tag, " quotient"}, bus.quotient, v.q);
    chk({tag, " remainder"}, bus.remainder, v.r);
    chk({tag, " div_by_zero"}, W'(bus.div_by_zero), W'(v.dz));
    chk({tag, " sub_a_finish"}, bus.sub_a, '0);
    chk({tag, " sub_b_finish"}, bus.sub_b, '0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, W'(bus.done), W'(0));
    chk({tag, " we_pulse"}, W'(bus.we), W'(0));
    chk({tag, " busy_idle"}, W'(bus.busy), W'(0));
    chk({tag, " result_held"}, bus.result, exp_res);
    chk({tag, " sub_a_idle"}, bus.sub_a, '0);
  endtask

  vec_t         tbl[6];
  vec_t         v;
  int           lat;
  logic [W-1:0] sb_first;
  logic         busy0;

  initial begin
    // Hand-derived vectors: {a, b, op, quotient, remainder, dz, latency}
    tbl[0] = '{32'd100,        32'd7,          OP_DIV, 32'd14,         32'd2,          1'b0, 32};
    tbl[1] = '{32'hFFFF_FFFF,  32'h8000_0001,  OP_MOD, 32'd1,          32'h7FFF_FFFE,  1'b0, 32};
    tbl[2] = '{32'd7,          32'd7,          OP_MOD, 32'd1,          32'd0,          1'b0, 32};
    tbl[3] = '{32'd5,          32'd9,          OP_DIV, 32'd0,          32'd5,          1'b0, 32};
    tbl[4] = '{32'd1234,       32'd0,          OP_DIV, 32'hFFFF_FFFF,  32'd1234,       1'b1, 0};
    tbl[5] = '{32'hDEAD_BEEF,  32'h0001_0000,  OP_MOD, 32'h0000_DEAD,  32'h0000_BEEF,  1'b0, 32};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_DIV;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    chk("reset busy", W'(bus.busy), W'(0));
    chk("reset done", W'(bus.done), W'(0));
    chk("reset result", bus.result, '0);
    chk("reset quotient", bus.quotient, '0);
    chk("reset sub_a", bus.sub_a, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i], 1'b0, lat, sb_first, busy0);
      verify($sformatf("tbl%0d", i), tbl[i], lat, sb_first, busy0);
    end

    // Start held high with changing operands through DIVIDE and FINISH.
    v = model(32'd1000, 32'd33, OP_DIV);
    do_op(v, 1'b1, lat, sb_first, busy0);
    verify("hold_start", v, lat, sb_first, busy0);
    v = model(32'd77, 32'd0, OP_MOD);
    do_op(v, 1'b1, lat, sb_first, busy0);
    verify("hold_start_dz", v, lat, sb_first, busy0);

    // Asynchronous reset in the middle of DIVIDE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.op    = OP_MOD;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset busy", W'(bus.busy), W'(0));
    chk("midreset done", W'(bus.done), W'(0));
    chk("midreset we", W'(bus.we), W'(0));
    chk("midreset result", bus.result, '0);
    chk("midreset quotient", bus.quotient, '0);
    chk("midreset remainder", bus.remainder, '0);
    chk("midreset div_by_zero", W'(bus.div_by_zero), W'(0));
    chk("midreset sub_a", bus.sub_a, '0);
    chk("midreset sub_b", bus.sub_b, '0);
    @(negedge clk);
    rst = 1'b0;
    v = model(32'd9, 32'd2, OP_DIV);
    do_op(v, 1'b0, lat, sb_first, busy0);
    verify("after_reset", v, lat, sb_first, busy0);

    // Randomized operands against the arithmetic reference model.
    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] ra, rb;
      int           mode;
      ra   = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0:       rb = '0;
        1, 2, 3: rb = W'($urandom_range(1, 255));
        4, 5:    rb = $urandom;
        default: rb = $urandom | 32'h8000_0000;
      endcase
      v = model(ra, rb, 1'($urandom_range(0, 1)));
      do_op(v, 1'b0, lat, sb_first, busy0);
      verify($sformatf("rand%0d", i), v, lat, sb_first, busy0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_divmod_ctrl

`default_nettype wire
